// File: rtl/wrr_packet_scheduler_if.sv
// Handshake and configuration bundle between the WRR packet scheduler and the read engine.
// master = scheduler side, slave = downstream/config side.
interface wrr_packet_scheduler_if #(
    parameter int NUM_Q        = 8,
    parameter int PRIORITY_BIT = 3,
    parameter int WEIGHT_BIT   = 4
);
    logic                          cfg_load;
    logic [NUM_Q*WEIGHT_BIT-1:0]   cfg_weight;
    logic [NUM_Q-1:0]              q_nonempty;
    logic                          grant_ack;
    logic                          pkt_done;
    logic                          grant_vld;
    logic [PRIORITY_BIT-1:0]       grant_q;
    logic                          xfer_busy;
    logic                          round_done;

    modport master (
        input  cfg_load, cfg_weight, q_nonempty, grant_ack, pkt_done,
        output grant_vld, grant_q, xfer_busy, round_done
    );

    modport slave (
        output cfg_load, cfg_weight, q_nonempty, grant_ack, pkt_done,
        input  grant_vld, grant_q, xfer_busy, round_done
    );
endinterface

// File: rtl/wrr_packet_scheduler.sv
// Packet-level weighted round-robin scheduler: one grant per packet, held until the
// read engine reports end-of-packet; credits reload when no eligible queue has credit left.
module wrr_packet_scheduler #(
    parameter int NUM_Q          = 8,
    parameter int PRIORITY_BIT   = 3,
    parameter int WEIGHT_BIT     = 4,
    parameter int DEFAULT_WEIGHT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wrr_packet_scheduler_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RELOAD, S_GRANT, S_XFER} state_t;

    state_t                  r_state;
    logic [WEIGHT_BIT-1:0]   r_weight [NUM_Q];
    logic [WEIGHT_BIT-1:0]   r_credit [NUM_Q];
    logic [PRIORITY_BIT-1:0] r_ptr;
    logic [PRIORITY_BIT-1:0] r_grant_q;
    logic                    r_grant_vld;
    logic                    r_xfer_busy;
    logic                    r_round_done;

    logic [NUM_Q-1:0]        w_elig;
    logic [NUM_Q-1:0]        w_pend;
    logic                    w_found;
    logic                    w_pending;
    logic [PRIORITY_BIT-1:0] w_sel;
    logic [PRIORITY_BIT-1:0] w_idx;
    logic [WEIGHT_BIT-1:0]   w_dec;

    always_comb begin
        w_elig = '0;
        w_pend = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            w_pend[i] = bus.q_nonempty[i] && (r_weight[i] != '0);
            w_elig[i] = w_pend[i] && (r_credit[i] != '0);
        end
        w_pending = |w_pend;
    end

    // Cyclic first-match search starting at r_ptr (inclusive); index add wraps naturally.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int unsigned j = 0; j < NUM_Q; j++) begin
            w_idx = r_ptr + PRIORITY_BIT'(j);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_dec = r_credit[r_grant_q] - WEIGHT_BIT'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_grant_q    <= '0;
            r_grant_vld  <= 1'b0;
            r_xfer_busy  <= 1'b0;
            r_round_done <= 1'b0;
            for (int unsigned i = 0; i < NUM_Q; i++) begin
                r_weight[i] <= WEIGHT_BIT'(DEFAULT_WEIGHT);
                r_credit[i] <= WEIGHT_BIT'(DEFAULT_WEIGHT);
            end
        end else begin
            if (bus.cfg_load) begin
                for (int unsigned i = 0; i < NUM_Q; i++) begin
                    r_weight[i] <= bus.cfg_weight[i*WEIGHT_BIT +: WEIGHT_BIT];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_q   <= w_sel;
                        r_grant_vld <= 1'b1;
                        r_state     <= S_GRANT;
                    end else if (w_pending) begin
                        r_round_done <= 1'b1;
                        r_state      <= S_RELOAD;
                    end
                end
                S_RELOAD: begin
                    // Reads pre-load weights even if cfg_load is active this cycle.
                    for (int unsigned i = 0; i < NUM_Q; i++) begin
                        r_credit[i] <= r_weight[i];
                    end
                    r_round_done <= 1'b0;
                    r_state      <= S_IDLE;
                end
                S_GRANT: begin
                    if (bus.grant_ack) begin
                        r_credit[r_grant_q] <= w_dec;
                        r_ptr       <= (w_dec != '0) ? r_grant_q : r_grant_q + PRIORITY_BIT'(1);
                        r_grant_vld <= 1'b0;
                        r_xfer_busy <= 1'b1;
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus.pkt_done) begin
                        r_xfer_busy <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant_vld  = r_grant_vld;
    assign bus.grant_q    = r_grant_q;
    assign bus.xfer_busy  = r_xfer_busy;
    assign bus.round_done = r_round_done;
endmodule

// File: doc/wrr_packet_scheduler.md
# wrr_packet_scheduler

Packet-level weighted round-robin scheduler for the priority-queue FIFO datapath. It picks which non-empty priority queue sends its next packet to the read side, and hands out one grant per packet. It holds that grant until the downstream read engine signals end-of-packet. Each queue receives up to `weight` packets per round; all credits reload when no remaining eligible queue has credit.

## Interface
Parameters:
- `NUM_Q`, 8: number of priority queues.
- `PRIORITY_BIT`, 3: width of queue index; `2**PRIORITY_BIT == NUM_Q`.
- `WEIGHT_BIT`, 4: per-queue weight and credit width.
- `DEFAULT_WEIGHT`, 1: weight of every queue after reset.

Ports (one clock `clk`; reset `rst_n` is synchronous and active-low):
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `cfg_load`  in  1  latch `cfg_weight` into weight registers this cycle.
- `cfg_weight`  in  NUM_Q*WEIGHT_BIT  packed weights; queue i at bits [i*WEIGHT_BIT +: WEIGHT_BIT].
- `q_nonempty`  in  NUM_Q  bit i = queue i holds at least one complete packet.
- `grant_ack`  in  1  downstream accepts the current grant.
- `pkt_done`  in  1  downstream finished reading granted packet (o_eop seen).
- `grant_vld`  out  1  grant valid; held until `grant_ack`.
- `grant_q`  out  PRIORITY_BIT  granted queue index; stable while `grant_vld` or `xfer_busy`.
- `xfer_busy`  out  1  packet transfer in progress.
- `round_done`  out  1  one-cycle pulse when credits reload.

## Operation
- Registers: `weight[i]`, `credit[i]` (WEIGHT_BIT each), search pointer `ptr` (PRIORITY_BIT), and a state machine.
- States: IDLE, RELOAD, GRANT, XFER.
- Eligible(i) = `q_nonempty[i] && weight[i]!=0 && credit[i]!=0`.
- Pending(i) = `q_nonempty[i] && weight[i]!=0`.
- IDLE:
  - Search cyclically from `ptr` inclusive (ptr, ptr+1, … wrapping mod NUM_Q).
  - On the first eligible queue k: register `grant_q<=k`, go to GRANT.
  - If no queue is eligible but some queue is pending: go to RELOAD.
  - Otherwise stay in IDLE.
- RELOAD: `credit[i]<=weight[i]` for all i, `round_done=1`, `ptr` unchanged, go to IDLE.
- GRANT:
  - `grant_vld=1`.
  - On `grant_ack`: `credit[grant_q]` decrements by 1.
  - `ptr<=grant_q` if the decremented credit is non-zero, else `grant_q+1` (wraps).
  - Go to XFER.
- XFER: `xfer_busy=1`; on `pkt_done` go to IDLE.
- Weight 0 disables a queue: it is never granted and never triggers RELOAD.
- `cfg_load` (any state) updates only the weight registers; credits change at the next RELOAD. A queue whose new weight is 0 becomes ineligible immediately.
- Credit never underflows, because a grant requires credit != 0. Pointer arithmetic wraps modulo NUM_Q.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - state IDLE; `grant_vld`=0, `grant_q`=0, `xfer_busy`=0, `round_done`=0;
  - `ptr`=0; `weight[i]`=`credit[i]`=DEFAULT_WEIGHT.
- `grant_vld`, `xfer_busy` and `round_done` are registered outputs (decoded from registered state).
- Latency:
  - Eligible queue in IDLE at edge t -> `grant_vld`=1 after edge t+1.
  - Credit-exhausted case (RELOAD needed) -> `grant_vld`=1 after edge t+3.
- `grant_ack` in the first GRANT cycle -> `xfer_busy`=1 next cycle.
- After `pkt_done` -> IDLE; the earliest next grant is 2 cycles after `pkt_done`.
- `grant_ack` is ignored outside GRANT.
- `pkt_done` is ignored outside XFER, including when it is coincident with `grant_ack` in GRANT.
- `q_nonempty` dropping during GRANT/XFER: the grant is not withdrawn.
- Reset mid-GRANT/XFER: the grant is abandoned and no credit is restored; downstream must reset together with this block.
- `cfg_load` in the same cycle as RELOAD: RELOAD uses the old weights, and the new weights are visible from the next cycle.

## Test plan
- Reset, then `q_nonempty`=8'h01 with ack/done each packet -> grants queue 0 repeatedly; `round_done` pulses after every grant (weight 1).
- Weights q0=3, q1=1, others 0; `q_nonempty`=8'h03; ack immediately; `pkt_done` 4 cycles later -> grant sequence 0,0,0,1 repeating; `round_done` once per 4 grants.
- All weights 1, `q_nonempty`=8'hFF -> grants 0..7 in order, then wrap to 0; `round_done` after the 8th grant.
- `grant_ack` delayed 5 cycles -> `grant_vld` and `grant_q` stable for 5 cycles; credit decrements exactly once.
- `pkt_done` asserted during GRANT and in IDLE -> no state change. Reset asserted during XFER -> all outputs 0 next cycle, `ptr`=0.
- `cfg_load` sets q2 weight to 0 while q2 is non-empty with credit 1 -> q2 is never granted again; `q_nonempty`=8'h04 alone -> stays in IDLE, no RELOAD.
